card_dealer: RTL

//  Consumes the 32-bit pseudo-random word from the game's random source and deals unique cards

---
 rtl/card_dealer_if.sv | 24 ++
 rtl/card_dealer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/card_dealer_if.sv
// Request/response bundle between the game FSM (master) and the card dealer (slave).
interface card_dealer_if;
  logic [31:0] randnum;
  logic        shuffle;
  logic        deal_req;
  logic        deal_valid;
  logic [5:0]  card;
  logic [3:0]  rank;
  logic [1:0]  suit;
  logic [5:0]  cards_left;
  logic        deck_empty;
  logic        busy;
  logic        deal_err;

  modport master (
    output randnum, shuffle, deal_req,
    input  deal_valid, card, rank, suit, cards_left, deck_empty, busy, deal_err
  );

  modport slave (
    input  randnum, shuffle, deal_req,
    output deal_valid, card, rank, suit, cards_left, deck_empty, busy, deal_err
  );
endinterface

// File: rtl/card_dealer.sv
// Deals unique cards from a 52-card deck: folds a random seed to 0..51, then
// probes forward one slot per clock past cards already dealt.
module card_dealer #(
  parameter int unsigned RAND_LSB     = 0,
  parameter bit          AUTO_SHUFFLE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  card_dealer_if.slave bus
);

  typedef enum logic {IDLE, PROBE} state_t;

  state_t      r_state, w_state_nxt;
  logic [51:0] r_dealt, w_dealt_nxt;
  logic [5:0]  r_ptr, w_ptr_nxt;
  logic [5:0]  r_card, w_card_nxt;
  logic [3:0]  r_rank, w_rank_nxt;
  logic [1:0]  r_suit, w_suit_nxt;
  logic [5:0]  r_left, w_left_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_err, w_err_nxt;
  logic        r_empty, w_empty_nxt;
  logic        r_busy, w_busy_nxt;
  logic [5:0]  w_seed;
  logic [5:0]  w_fold;

  assign w_seed = bus.randnum[RAND_LSB +: 6];
  assign w_fold = (w_seed >= 6'd52) ? (w_seed - 6'd52) : w_seed;

  // Rank/suit by range compare and constant subtract instead of a divider.
  function automatic logic [5:0] f_rank_suit(input logic [5:0] idx);
    logic [1:0] suit;
    logic [5:0] base;
    logic [5:0] rank_w;
    if (idx < 6'd13) begin
      suit = 2'd0; base = 6'd0;
    end else if (idx < 6'd26) begin
      suit = 2'd1; base = 6'd13;
    end else if (idx < 6'd39) begin
      suit = 2'd2; base = 6'd26;
    end else begin
      suit = 2'd3; base = 6'd39;
    end
    rank_w = idx - base + 6'd1;
    return {rank_w[3:0], suit};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_dealt_nxt = r_dealt;
    w_ptr_nxt   = r_ptr;
    w_card_nxt  = r_card;
    w_rank_nxt  = r_rank;
    w_suit_nxt  = r_suit;
    w_left_nxt  = r_left;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (bus.shuffle) begin
      w_dealt_nxt = '0;
      w_left_nxt  = 6'd52;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          // r_valid blocks the request arriving in the same cycle as a dealt card.
          if (bus.deal_req && !r_valid) begin
            if (r_empty && !AUTO_SHUFFLE) begin
              w_err_nxt = 1'b1;
            end else begin
              if (r_empty) begin
                w_dealt_nxt = '0;
                w_left_nxt  = 6'd52;
              end
              w_ptr_nxt   = w_fold;
              w_state_nxt = PROBE;
            end
          end
        end
        PROBE: begin
          if (r_dealt[r_ptr]) begin
            w_ptr_nxt = (r_ptr == 6'd51) ? 6'd0 : (r_ptr + 6'd1);
          end else begin
            w_dealt_nxt[r_ptr]       = 1'b1;
            w_card_nxt               = r_ptr;
            {w_rank_nxt, w_suit_nxt} = f_rank_suit(r_ptr);
            if (r_left != 6'd0) begin
              w_left_nxt = r_left - 6'd1;
            end
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      endcase
    end
    w_empty_nxt = (w_left_nxt == 6'd0);
    w_busy_nxt  = (w_state_nxt == PROBE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dealt <= '0;
      r_ptr   <= '0;
      r_card  <= '0;
      r_rank  <= '0;
      r_suit  <= '0;
      r_left  <= 6'd52;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_empty <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dealt <= w_dealt_nxt;
      r_ptr   <= w_ptr_nxt;
      r_card  <= w_card_nxt;
      r_rank  <= w_rank_nxt;
      r_suit  <= w_suit_nxt;
      r_left  <= w_left_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_empty <= w_empty_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.deal_valid = r_valid;
  assign bus.card       = r_card;
  assign bus.rank       = r_rank;
  assign bus.suit       = r_suit;
  assign bus.cards_left = r_left;
  assign bus.deck_empty = r_empty;
  assign bus.busy       = r_busy;
  assign bus.deal_err   = r_err;

endmodule
